bus_dma_master: RTL

//  Word-copy DMA engine; second bus master (M2 port of the shared-bus arbiter), the initiator side of the

---
 rtl/bus_dma_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/bus_dma_master.sv
// Word-copy DMA engine. The CPU programs SRC/DST/LEN/CTRL through a small slave window. The
// engine then copies LEN words over the shared master bus, one read/write pair per word, and
// flags completion through a sticky DONE bit and a level interrupt.
module bus_dma_master #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Slave register window
  input  logic              sCS_,
  input  logic              sAs_,
  input  logic              sRW,
  input  logic [1:0]        sAddr,
  input  logic [DATA_W-1:0] sWrData,
  output logic [DATA_W-1:0] sRdData,
  output logic              sRdy_,
  // Master port
  output logic              mReq_,
  input  logic              mGrnt_,
  output logic [ADDR_W-1:0] mAddr,
  output logic              mAs_,
  output logic              mRW,
  output logic [DATA_W-1:0] mWrData,
  input  logic [DATA_W-1:0] mRdData,
  input  logic              mRdy_,
  // Completion interrupt
  output logic              irq
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StAcc  = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StGap  = 3'd4;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic              done_q;
  logic              ie_q;
  logic [2:0]        state_q;
  logic              ph_q;      // 0 = read phase, 1 = write phase
  logic [DATA_W-1:0] wdata_q;
  logic              irq_q;

  logic              acc_q;
  logic              acc_rd_q;
  logic [1:0]        acc_addr_q;
  logic              srdy_q;
  logic [DATA_W-1:0] srdata_q;
  logic [DATA_W-1:0] rd_mux;

  logic              acc;
  logic              wr_en;
  logic              busy;
  logic              unused_wdata;

  assign acc   = ~sCS_ & ~sAs_;
  assign wr_en = acc & ~sRW;
  assign busy  = (state_q != StIdle);

  // Upper write-data bits have no register behind them.
  assign unused_wdata = ^sWrData[DATA_W-1:ADDR_W];

  // Register read mux, indexed by the access captured on the previous edge.
  always_comb begin
    rd_mux = '0;
    case (acc_addr_q)
      2'd0:    rd_mux = DATA_W'(src_q);
      2'd1:    rd_mux = DATA_W'(dst_q);
      2'd2:    rd_mux = DATA_W'(len_q);
      default: rd_mux = {{(DATA_W-3){1'b0}}, ie_q, done_q, busy};
    endcase
  end

  // Slave response pipeline: capture access at one edge, answer with sRdy_ at the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= 1'b0;
      acc_rd_q   <= 1'b0;
      acc_addr_q <= 2'd0;
      srdy_q     <= 1'b1;
      srdata_q   <= '0;
    end else begin
      acc_q      <= acc;
      acc_rd_q   <= acc & sRW;
      acc_addr_q <= sAddr;
      srdy_q     <= ~acc_q;
      srdata_q   <= acc_rd_q ? rd_mux : '0;
    end
  end

  // Register writes and the copy FSM share state (SRC/DST/LEN/DONE), so they live together.
  // Statement order matters: a completion setting DONE overrides a same-cycle DONE clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      state_q <= StIdle;
      ph_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (wr_en && !busy) begin
        case (sAddr)
          2'd0:    src_q <= sWrData[ADDR_W-1:0];
          2'd1:    dst_q <= sWrData[ADDR_W-1:0];
          2'd2:    len_q <= sWrData[LEN_W-1:0];
          default: ;
        endcase
      end
      if (wr_en && (sAddr == 2'd3)) begin
        ie_q <= sWrData[2];
        if (sWrData[1]) done_q <= 1'b0;
        if (sWrData[0] && !busy) begin
          if (len_q == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= StReq;
            ph_q    <= 1'b0;
          end
        end
      end

      case (state_q)
        StIdle: ;
        StReq:  if (!mGrnt_) state_q <= StAcc;
        StAcc:  state_q <= StWait;
        StWait: begin
          if (!mRdy_) begin
            state_q <= StGap;
            if (!ph_q) wdata_q <= mRdData;
          end
        end
        StGap: begin
          if (!ph_q) begin
            ph_q    <= 1'b1;
            state_q <= StReq;
          end else begin
            src_q <= src_q + ADDR_W'(1);
            dst_q <= dst_q + ADDR_W'(1);
            len_q <= len_q - LEN_W'(1);
            ph_q  <= 1'b0;
            if (len_q == LEN_W'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              state_q <= StReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Interrupt follows DONE & IE one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= done_q & ie_q;
  end

  // Master outputs decode straight from state so reset releases the bus immediately.
  assign mReq_   = ~((state_q == StReq) || (state_q == StAcc) || (state_q == StWait));
  assign mAs_    = ~(state_q == StAcc);
  assign mRW     = ~ph_q;
  assign mAddr   = ph_q ? dst_q : src_q;
  assign mWrData = wdata_q;

  assign sRdy_   = srdy_q;
  assign sRdData = srdata_q;
  assign irq     = irq_q;

endmodule
